// File: rtl/fir_pkg.sv
// Shared types and constant helpers for the reloadable streaming FIR.
// Loader state encodings, width helpers and the power-up tap pattern.
package fir_pkg;

  typedef enum logic [1:0] {
    CIDLE = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } coef_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int acc_width(
    input int xw,
    input int tw,
    input int n
  );
    return xw + tw + clog2(n);
  endfunction

  // Passthrough bank: unity on tap 0
  function automatic int reset_tap(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// Framed coefficient loader: shadow bank fill, framing checks and an
// atomic commit of the whole bank into the active set.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int NBR_OF_TAPS = 4,
  parameter int TAP_SIZE    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [TAP_SIZE-1:0]             s_coef_tdata,
  input  logic                            s_coef_tvalid,
  input  logic                            s_coef_tlast,
  output logic [NBR_OF_TAPS*TAP_SIZE-1:0] bank,
  output logic                            coef_busy,
  output logic                            coef_done,
  output logic                            coef_err
);

  localparam int CW = clog2(NBR_OF_TAPS);
  localparam logic [CW-1:0] LASTI = CW'(NBR_OF_TAPS - 1);

  coef_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [TAP_SIZE-1:0] shadow [NBR_OF_TAPS];
  logic [TAP_SIZE-1:0] active [NBR_OF_TAPS];

  logic at_end;
  logic ld_first;
  logic ld_next;
  logic commit;
  logic err_set;

  assign at_end = (cnt == LASTI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CIDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    ld_first = 1'b0;
    ld_next  = 1'b0;
    commit   = 1'b0;
    err_set  = 1'b0;
    if (s_coef_tvalid) begin
      unique case (state)
        CIDLE: begin
          ld_first = 1'b1;
          if (s_coef_tlast) err_set = 1'b1;
          else              nxt = LOAD;
        end
        LOAD: begin
          unique case (1'b1)
            (!at_end && s_coef_tlast): begin
              err_set = 1'b1;
              nxt     = CIDLE;
            end
            (!at_end && !s_coef_tlast): begin
              ld_next = 1'b1;
            end
            (at_end && s_coef_tlast): begin
              commit = 1'b1;
              nxt    = CIDLE;
            end
            default: begin
              err_set = 1'b1;
              nxt     = DRAIN;
            end
          endcase
        end
        DRAIN: begin
          if (s_coef_tlast) nxt = CIDLE;
        end
        default: nxt = CIDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      coef_done <= 1'b0;
      coef_err  <= 1'b0;
      for (int k = 0; k < NBR_OF_TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= TAP_SIZE'(reset_tap(k));
      end
    end else begin
      coef_done <= commit;
      if (err_set)     coef_err <= 1'b1;
      else if (commit) coef_err <= 1'b0;
      if (ld_first) begin
        shadow[0] <= s_coef_tdata;
        cnt       <= CW'(1);
      end
      if (ld_next) begin
        shadow[cnt] <= s_coef_tdata;
        cnt         <= cnt + CW'(1);
      end
      // Final beat goes straight into the active set with the rest
      if (commit) begin
        for (int k = 0; k < NBR_OF_TAPS; k++)
          active[k] <= (k == NBR_OF_TAPS - 1) ?
                       s_coef_tdata : shadow[k];
      end
    end
  end

  assign coef_busy = (state != CIDLE);

  for (genvar k = 0; k < NBR_OF_TAPS; k++) begin : g_bank
    assign bank[k*TAP_SIZE +: TAP_SIZE] = active[k];
  end

endmodule

// File: rtl/fir_stream_reload.sv
// Streaming FIR with run-time coefficient reload, full-precision MAC,
// arithmetic output shift and signed saturation.
module fir_stream_reload
  import fir_pkg::*;
#(
  parameter int NBR_OF_TAPS = 4,
  parameter int TAP_SIZE    = 8,
  parameter int X_N_SIZE    = 8,
  parameter int Y_N_SIZE    = 16,
  parameter int OUT_SHIFT   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [X_N_SIZE-1:0] x_n,
  input  logic                s_axis_fir_tvalid,
  input  logic [TAP_SIZE-1:0] s_coef_tdata,
  input  logic                s_coef_tvalid,
  input  logic                s_coef_tlast,
  output logic [Y_N_SIZE-1:0] y_n,
  output logic                m_axis_fir_tvalid,
  output logic                sat_flag,
  output logic                coef_busy,
  output logic                coef_done,
  output logic                coef_err
);

  localparam int ACC_W = acc_width(X_N_SIZE, TAP_SIZE, NBR_OF_TAPS);
  localparam int W     = ACC_W + Y_N_SIZE;

  localparam logic signed [W-1:0] YMAX =
    {{(W-Y_N_SIZE+1){1'b0}}, {(Y_N_SIZE-1){1'b1}}};
  localparam logic signed [W-1:0] YMIN =
    {{(W-Y_N_SIZE+1){1'b1}}, {(Y_N_SIZE-1){1'b0}}};

  logic [NBR_OF_TAPS*TAP_SIZE-1:0] bank;
  logic signed [TAP_SIZE-1:0] coef  [NBR_OF_TAPS];
  logic signed [X_N_SIZE-1:0] buffs [NBR_OF_TAPS];

  logic signed [ACC_W-1:0] mac;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] shf;
  logic signed [W-1:0]     ext;
  logic [Y_N_SIZE-1:0]     y_sat;
  logic clip;
  logic v_buf;
  logic v_acc;

  fir_coef_loader #(
    .NBR_OF_TAPS(NBR_OF_TAPS),
    .TAP_SIZE   (TAP_SIZE)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .s_coef_tdata (s_coef_tdata),
    .s_coef_tvalid(s_coef_tvalid),
    .s_coef_tlast (s_coef_tlast),
    .bank         (bank),
    .coef_busy    (coef_busy),
    .coef_done    (coef_done),
    .coef_err     (coef_err)
  );

  for (genvar k = 0; k < NBR_OF_TAPS; k++) begin : g_coef
    assign coef[k] = bank[k*TAP_SIZE +: TAP_SIZE];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NBR_OF_TAPS; k++) buffs[k] <= '0;
    end else if (s_axis_fir_tvalid) begin
      buffs[0] <= x_n;
      for (int k = 1; k < NBR_OF_TAPS; k++) buffs[k] <= buffs[k-1];
    end
  end

  always_comb begin
    mac = '0;
    for (int k = 0; k < NBR_OF_TAPS; k++)
      mac = mac + ACC_W'(coef[k]) * ACC_W'(buffs[k]);
  end

  assign shf  = acc_r >>> OUT_SHIFT;
  assign ext  = W'(shf);
  assign clip = (ext > YMAX) || (ext < YMIN);

  always_comb begin
    y_sat = ext[Y_N_SIZE-1:0];
    if (ext > YMAX)      y_sat = YMAX[Y_N_SIZE-1:0];
    else if (ext < YMIN) y_sat = YMIN[Y_N_SIZE-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_buf             <= 1'b0;
      v_acc             <= 1'b0;
      acc_r             <= '0;
      y_n               <= '0;
      m_axis_fir_tvalid <= 1'b0;
      sat_flag          <= 1'b0;
    end else begin
      v_buf             <= s_axis_fir_tvalid;
      v_acc             <= v_buf;
      acc_r             <= mac;
      m_axis_fir_tvalid <= v_acc;
      sat_flag          <= v_acc & clip;
      if (v_acc) y_n <= y_sat;
    end
  end

endmodule

// File: tb/tb_fir_stream_reload.sv
// Directed bench for fir_stream_reload: a 16-bit and an 8-bit output
// instance share all inputs; expected values are hand-computed.
module tb_fir_stream_reload;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  x_n   = '0;
  logic        xv    = 1'b0;
  logic [7:0]  cd    = '0;
  logic        cv    = 1'b0;
  logic        cl    = 1'b0;

  logic [15:0] y16;
  logic        v16, s16, busy, done, err;
  logic [7:0]  y8;
  logic        v8, s8, busy8, done8, err8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_stream_reload #(
    .NBR_OF_TAPS(4), .TAP_SIZE(8), .X_N_SIZE(8),
    .Y_N_SIZE(16), .OUT_SHIFT(0)
  ) u_dut (
    .clk(clk), .reset(reset), .x_n(x_n),
    .s_axis_fir_tvalid(xv),
    .s_coef_tdata(cd), .s_coef_tvalid(cv), .s_coef_tlast(cl),
    .y_n(y16), .m_axis_fir_tvalid(v16), .sat_flag(s16),
    .coef_busy(busy), .coef_done(done), .coef_err(err)
  );

  fir_stream_reload #(
    .NBR_OF_TAPS(4), .TAP_SIZE(8), .X_N_SIZE(8),
    .Y_N_SIZE(8), .OUT_SHIFT(0)
  ) u_sat (
    .clk(clk), .reset(reset), .x_n(x_n),
    .s_axis_fir_tvalid(xv),
    .s_coef_tdata(cd), .s_coef_tvalid(cv), .s_coef_tlast(cl),
    .y_n(y8), .m_axis_fir_tvalid(v8), .sat_flag(s8),
    .coef_busy(busy8), .coef_done(done8), .coef_err(err8)
  );

  task automatic push(input int x, input logic v);
    x_n = 8'(x);
    xv  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input logic last);
    xv = 1'b0;
    cd = 8'(d);
    cv = 1'b1;
    cl = last;
    @(posedge clk);
    #1;
    cv = 1'b0;
    cl = 1'b0;
  endtask

  task automatic flush;
    repeat (6) push(0, 1'b1);
    xv = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({y16, v16, s16, busy, done, err} !== 22'd0) begin
      failures++;
      $display("FAIL reset_main outs=%h required 0",
               {y16, v16, s16, busy, done, err});
    end
    checks++;
    if ({y8, v8, s8, busy8, done8, err8} !== 14'd0) begin
      failures++;
      $display("FAIL reset_sat outs=%h required 0",
               {y8, v8, s8, busy8, done8, err8});
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_impulse;
    int e [4];
    e = '{5, 0, 0, 0};
    push(5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push(0, 1'b1);
      if (i == 0) begin
        checks++;
        if (v16 !== 1'b0) begin
          failures++;
          $display("FAIL impulse_latency tvalid=%b required 0", v16);
        end
      end else begin
        checks++;
        if (y16 !== 16'(e[i-1]) || v16 !== 1'b1) begin
          failures++;
          $display("FAIL impulse[%0d] y_n=%0d v=%b required %0d v=1",
                   i-1, $signed(y16), v16, e[i-1]);
        end
      end
    end
    xv = 1'b0;
    repeat (3) push(0, 1'b0);
    checks++;
    if (v16 !== 1'b0 || s16 !== 1'b0 || y16 !== 16'd0) begin
      failures++;
      $display("FAIL idle_hold y_n=%0d v=%b sat=%b required 0 0 0",
               $signed(y16), v16, s16);
    end
  endtask

  task automatic test_load;
    int e [4];
    e = '{5, -10, 15, 20};
    beat(1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL load_busy busy=%b required 1", busy);
    end
    beat(-2, 1'b0);
    beat(3, 1'b0);
    beat(4, 1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL load_commit done=%b busy=%b err=%b required 1 0 0",
               done, busy, err);
    end
    push(0, 1'b0);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse done=%b required 0", done);
    end
    flush;
    push(5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push(0, 1'b1);
      if (i > 0) begin
        checks++;
        if (y16 !== 16'(e[i-1]) || v16 !== 1'b1) begin
          failures++;
          $display("FAIL load_resp[%0d] y_n=%0d required %0d",
                   i-1, $signed(y16), e[i-1]);
        end
      end
    end
  endtask

  task automatic test_frame_err;
    int e [4];
    e = '{5, -10, 15, 20};
    beat(7, 1'b0);
    beat(7, 1'b1);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL short_frame err=%b busy=%b done=%b required 1 0 0",
               err, busy, done);
    end
    flush;
    push(5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push(0, 1'b1);
      if (i > 0) begin
        checks++;
        if (y16 !== 16'(e[i-1])) begin
          failures++;
          $display("FAIL short_keep[%0d] y_n=%0d required %0d",
                   i-1, $signed(y16), e[i-1]);
        end
      end
    end
    repeat (4) beat(9, 1'b0);
    checks++;
    if (busy !== 1'b1 || err !== 1'b1) begin
      failures++;
      $display("FAIL long_drain busy=%b err=%b required 1 1", busy, err);
    end
    beat(9, 1'b1);
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL long_exit busy=%b err=%b done=%b required 0 1 0",
               busy, err, done);
    end
    beat(2, 1'b0);
    beat(1, 1'b0);
    beat(0, 1'b0);
    beat(-1, 1'b1);
    checks++;
    if (err !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL err_clear err=%b done=%b required 0 1", err, done);
    end
    e = '{10, 5, 0, -5};
    flush;
    push(5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push(0, 1'b1);
      if (i > 0) begin
        checks++;
        if (y16 !== 16'(e[i-1])) begin
          failures++;
          $display("FAIL new_resp[%0d] y_n=%0d required %0d",
                   i-1, $signed(y16), e[i-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int oldb [4];
    int newb [4];
    int ex;
    int s;
    oldb = '{2, 1, 0, -1};
    newb = '{1, 1, 1, 1};
    flush;
    for (int t = 0; t < 14; t++) begin
      x_n = 8'(t + 1);
      xv  = 1'b1;
      if (t >= 3 && t <= 6) begin
        cd = 8'(newb[t-3]);
        cv = 1'b1;
        cl = (t == 6);
      end else begin
        cv = 1'b0;
        cl = 1'b0;
      end
      @(posedge clk);
      #1;
      if (t == 6) begin
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL stream_commit done=%b required 1", done);
        end
      end
      if (t >= 2) begin
        s  = t - 2;
        ex = 0;
        for (int k = 0; k < 4; k++) begin
          if (s - k >= 0)
            ex += ((s + 1 > 6) ? newb[k] : oldb[k]) * (s - k + 1);
        end
        checks++;
        if (y16 !== 16'(ex) || v16 !== 1'b1) begin
          failures++;
          $display("FAIL stream[%0d] y_n=%0d v=%b required %0d v=1",
                   s, $signed(y16), v16, ex);
        end
      end
    end
    cv = 1'b0;
    cl = 1'b0;
    xv = 1'b0;
  endtask

  task automatic test_saturation;
    repeat (3) beat(127, 1'b0);
    beat(127, 1'b1);
    repeat (6) push(127, 1'b1);
    checks++;
    if (y8 !== 8'h7f || s8 !== 1'b1 || v8 !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos8 y_n=%0d sat=%b required 127 1",
               $signed(y8), s8);
    end
    checks++;
    if (y16 !== 16'h7fff || s16 !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos16 y_n=%0d sat=%b required 32767 1",
               $signed(y16), s16);
    end
    repeat (6) push(-128, 1'b1);
    checks++;
    if (y8 !== 8'h80 || s8 !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg8 y_n=%0d sat=%b required -128 1",
               $signed(y8), s8);
    end
    checks++;
    if (y16 !== 16'h8000 || s16 !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg16 y_n=%0d sat=%b required -32768 1",
               $signed(y16), s16);
    end
    repeat (6) push(0, 1'b1);
    checks++;
    if (y8 !== 8'd0 || s8 !== 1'b0 || s16 !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear y_n=%0d sat8=%b sat16=%b required 0 0 0",
               $signed(y8), s8, s16);
    end
    xv = 1'b0;
  endtask

  task automatic test_reset_mid_load;
    int e [4];
    e = '{5, 0, 0, 0};
    beat(3, 1'b1);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_err err=%b required 1", err);
    end
    beat(9, 1'b0);
    beat(9, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_load_busy busy=%b required 1", busy);
    end
    push(7, 1'b1);
    push(7, 1'b1);
    push(7, 1'b1);
    reset = 1'b0;
    #2;
    checks++;
    if ({y16, v16, s16, busy, done, err} !== 22'd0) begin
      failures++;
      $display("FAIL async_reset outs=%h required 0",
               {y16, v16, s16, busy, done, err});
    end
    xv = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push(0, 1'b1);
      if (i > 0) begin
        checks++;
        if (y16 !== 16'(e[i-1]) || v16 !== 1'b1) begin
          failures++;
          $display("FAIL passthru[%0d] y_n=%0d required %0d",
                   i-1, $signed(y16), e[i-1]);
        end
      end
    end
    xv = 1'b0;
  endtask

  initial begin
    test_reset;
    test_impulse;
    test_load;
    test_frame_err;
    test_back_to_back;
    test_saturation;
    test_reset_mid_load;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
